// File: rtl/mem_branch_resolver.sv
// MEM-stage branch resolver with a saturating-counter branch history table and registered redirect.
// Optional per-event statistics counters are compiled in when BRANCH_STATS_EN is defined.
module mem_branch_resolver #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_BITS    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mem_valid,
   input  logic            mem_jump,
   input  logic            mem_branch,
   input  logic [2:0]      mem_cond,
   input  logic            alu_zero,
   input  logic            alu_lt,
   input  logic            alu_ltu,
   input  logic [XLEN-1:0] mem_pc,
   input  logic [XLEN-1:0] mem_target,
   input  logic            mem_pred_taken,
   input  logic [XLEN-1:0] if_pc,
`ifdef BRANCH_STATS_EN
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts,
   output logic [31:0]     stat_jumps,
`endif
   output logic            if_pred_taken,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);
   localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
   localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

   logic [CNT_BITS-1:0] r_bht [BHT_ENTRIES];
   logic                r_redirect;
   logic [XLEN-1:0]     r_redirect_pc;

   logic [IDX_W-1:0]    w_if_idx;
   logic [IDX_W-1:0]    w_mem_idx;
   logic                w_cond_taken;
   logic                w_taken;
   logic                w_resolved;
   logic                w_mispredict;
   logic                w_train;
   logic [CNT_BITS-1:0] w_cnt_cur;
   logic [CNT_BITS-1:0] w_cnt_next;
   logic                w_if_pc_unused;

   assign w_if_idx       = if_pc[IDX_W+1:2];
   assign w_mem_idx      = mem_pc[IDX_W+1:2];
   assign w_if_pc_unused = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

   always_comb begin
      w_cond_taken = 1'b0;
      case (mem_cond)
         3'd0:    w_cond_taken = alu_zero;
         3'd1:    w_cond_taken = ~alu_zero;
         3'd4:    w_cond_taken = alu_lt;
         3'd5:    w_cond_taken = ~alu_lt;
         3'd6:    w_cond_taken = alu_ltu;
         3'd7:    w_cond_taken = ~alu_ltu;
         default: w_cond_taken = 1'b0;
      endcase
   end

   assign w_taken      = mem_jump | w_cond_taken;
   assign w_resolved   = mem_valid & (mem_jump | mem_branch);
   assign w_mispredict = w_resolved & (w_taken != mem_pred_taken);
   assign w_train      = mem_valid & mem_branch & ~mem_jump;

   assign w_cnt_cur = r_bht[w_mem_idx];

   always_comb begin
      w_cnt_next = w_cnt_cur;
      if (w_taken) begin
         if (w_cnt_cur != CNT_MAX) w_cnt_next = w_cnt_cur + 1'b1;
      end else begin
         if (w_cnt_cur != '0) w_cnt_next = w_cnt_cur - 1'b1;
      end
   end

   // Lookup reads the stored value only; a same-cycle update is visible next cycle.
   assign if_pred_taken = r_bht[w_if_idx][CNT_BITS-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CNT_INIT;
      end else if (w_train) begin
         r_bht[w_mem_idx] <= w_cnt_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
      end else begin
         r_redirect <= w_mispredict;
         if (w_mispredict) r_redirect_pc <= w_taken ? mem_target : mem_pc + XLEN'(4);
      end
   end

   assign redirect    = r_redirect;
   assign redirect_pc = r_redirect_pc;

`ifdef BRANCH_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispredicts;
   logic [31:0] r_stat_jumps;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_branches    <= '0;
         r_stat_mispredicts <= '0;
         r_stat_jumps       <= '0;
      end else begin
         if (w_train)                r_stat_branches    <= r_stat_branches + 32'd1;
         if (w_mispredict)           r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
         if (mem_valid && mem_jump)  r_stat_jumps       <= r_stat_jumps + 32'd1;
      end
   end

   assign stat_branches    = r_stat_branches;
   assign stat_mispredicts = r_stat_mispredicts;
   assign stat_jumps       = r_stat_jumps;
`endif

endmodule

// File: tb/tb_mem_branch_resolver.sv
// Scoreboard bench for mem_branch_resolver: stimulus pushes expected redirects, a monitor pops them.
module tb_mem_branch_resolver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid, mem_jump, mem_branch;
   logic [2:0]  mem_cond;
   logic        alu_zero, alu_lt, alu_ltu;
   logic [31:0] mem_pc, mem_target, if_pc;
   logic        mem_pred_taken;
   logic        if_pred_taken, redirect;
   logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches, stat_mispredicts, stat_jumps;
`endif

   mem_branch_resolver dut (
      .clk(clk), .rst_n(rst_n),
      .mem_valid(mem_valid), .mem_jump(mem_jump), .mem_branch(mem_branch),
      .mem_cond(mem_cond), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
      .mem_pc(mem_pc), .mem_target(mem_target), .mem_pred_taken(mem_pred_taken),
      .if_pc(if_pc),
`ifdef BRANCH_STATS_EN
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts), .stat_jumps(stat_jumps),
`endif
      .if_pred_taken(if_pred_taken), .redirect(redirect), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   exp_br = 0, exp_mis = 0, exp_jmp = 0;

   always @(posedge clk) cyc++;

   // Monitor: every redirect must match the head of the scoreboard, in the expected cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0 && sb[0].due < cyc) begin
         checks++; errors++;
         $display("FAIL redirect_missing: expected pc %h in cycle %0d, redirect stayed low", sb[0].pc, sb[0].due);
         void'(sb.pop_front());
      end
      if (redirect === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL redirect_unexpected: got redirect pc %h in cycle %0d, required none", redirect_pc, cyc);
         end else begin
            e = sb.pop_front();
            if (e.due != cyc || redirect_pc !== e.pc) begin
               errors++;
               $display("FAIL redirect_pc: got %h in cycle %0d, required %h in cycle %0d", redirect_pc, cyc, e.pc, e.due);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
   endtask

   task automatic pred(input logic [31:0] pc, input logic want);
      if_pc = pc;
      #1;
      chk($sformatf("pred_%h", pc), {31'd0, if_pred_taken}, {31'd0, want});
   endtask

   // Drive one MEM-stage instruction; exp_taken is the hand-computed branch outcome.
   task automatic drive(input logic v, input logic j, input logic b, input logic [2:0] c,
                        input logic z, input logic lt, input logic ltu,
                        input logic [31:0] pc, input logic [31:0] tgt, input logic pt,
                        input logic exp_taken, input logic expect_out);
      exp_t e;
      mem_valid = v; mem_jump = j; mem_branch = b; mem_cond = c;
      alu_zero = z; alu_lt = lt; alu_ltu = ltu;
      mem_pc = pc; mem_target = tgt; mem_pred_taken = pt;
      if (expect_out && v && (j || b) && (exp_taken != pt)) begin
         e.due = cyc + 1;
         e.pc  = exp_taken ? tgt : pc + 32'd4;
         sb.push_back(e);
      end
      if (expect_out && v) begin
         if (b && !j) exp_br++;
         if (j) exp_jmp++;
         if ((j || b) && (exp_taken != pt)) exp_mis++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      mem_valid = 1'b0; mem_jump = 1'b0; mem_branch = 1'b0;
   endtask

   task automatic br(input logic j, input logic b, input logic [2:0] c,
                     input logic z, input logic lt, input logic ltu,
                     input logic [31:0] pc, input logic [31:0] tgt, input logic pt,
                     input logic exp_taken);
      drive(1'b1, j, b, c, z, lt, ltu, pc, tgt, pt, exp_taken, 1'b1);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      mem_valid = 0; mem_jump = 0; mem_branch = 0; mem_cond = 0;
      alu_zero = 0; alu_lt = 0; alu_ltu = 0;
      mem_pc = 0; mem_target = 0; mem_pred_taken = 0; if_pc = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      chk("reset_redirect", {31'd0, redirect}, 32'd0);
      chk("reset_redirect_pc", redirect_pc, 32'd0);
      pred(32'h100, 1'b0);

      // taken EQ mispredict, counter 1->2
      br(0, 1, 3'd0, 1, 0, 0, 32'h100, 32'h200, 0, 1);
      step();
      pred(32'h100, 1'b1);

      // three not-taken with pred=1: 2->1->0->0
      br(0, 1, 3'd0, 0, 0, 0, 32'h100, 32'h200, 1, 0);
      pred(32'h100, 1'b0);
      br(0, 1, 3'd0, 0, 0, 0, 32'h100, 32'h200, 1, 0);
      br(0, 1, 3'd0, 0, 0, 0, 32'h100, 32'h200, 1, 0);
      br(0, 1, 3'd0, 0, 0, 0, 32'h100, 32'h200, 0, 0);
      step();
      chk("redirect_pc_hold", redirect_pc, 32'h104);
      pred(32'h100, 1'b0);

      // BLTU vs BLT on lt=1, ltu=0; reserved code at 0x120
      br(0, 1, 3'd6, 0, 1, 0, 32'h120, 32'h500, 0, 0);
      br(0, 1, 3'd4, 0, 1, 0, 32'h120, 32'h500, 0, 1);
      pred(32'h120, 1'b0);
      br(0, 1, 3'd4, 0, 1, 0, 32'h120, 32'h500, 1, 1);
      pred(32'h120, 1'b1);
      br(0, 1, 3'd2, 1, 1, 1, 32'h120, 32'h500, 1, 0);
      pred(32'h120, 1'b0);

      // NE / GE / GEU at 0x140: 1->2->3->2
      br(0, 1, 3'd1, 0, 0, 0, 32'h140, 32'h600, 0, 1);
      br(0, 1, 3'd5, 0, 0, 0, 32'h140, 32'h600, 1, 1);
      br(0, 1, 3'd7, 0, 0, 1, 32'h140, 32'h600, 1, 0);
      pred(32'h140, 1'b1);

      // jumps never train, even with mem_branch set
      br(1, 1, 3'd0, 0, 0, 0, 32'hFFFF_FFFC, 32'h40, 0, 1);
      br(1, 0, 3'd0, 0, 0, 0, 32'hFFFF_FFFC, 32'h40, 1, 1);
      pred(32'hFFFF_FFFC, 1'b0);
      br(0, 1, 3'd0, 0, 0, 0, 32'hFFFF_FFFC, 32'h40, 1, 0);
      pred(32'hFFFF_FFFC, 1'b0);

      // invalid instruction: no redirect, no training
      drive(0, 0, 1, 3'd0, 1, 0, 0, 32'h100, 32'h900, 0, 1, 1);
      step();
      pred(32'h100, 1'b0);

      // collision: counter 0->1, then lookup 0x300 while training the same index
      br(0, 1, 3'd0, 1, 0, 0, 32'h100, 32'h200, 1, 1);
      drive(1, 0, 1, 3'd0, 1, 0, 0, 32'h300, 32'h700, 0, 1, 1);
      pred(32'h300, 1'b0);
      step();
      pred(32'h300, 1'b1);

      // back-to-back same index: 1->2->3, then 3->2
      drive(1, 0, 1, 3'd0, 1, 0, 0, 32'h180, 32'h800, 0, 1, 1);
      @(posedge clk); #1;
      drive(1, 0, 1, 3'd0, 1, 0, 0, 32'h180, 32'h800, 0, 1, 1);
      step();
      br(0, 1, 3'd0, 0, 0, 0, 32'h180, 32'h800, 1, 0);
      pred(32'h180, 1'b1);

`ifdef BRANCH_STATS_EN
      step(); step();
      chk("stat_branches", stat_branches, exp_br);
      chk("stat_mispredicts", stat_mispredicts, exp_mis);
      chk("stat_jumps", stat_jumps, exp_jmp);
`endif

      // reset lands before the resolving edge: redirect and training dropped
      br(0, 1, 3'd0, 1, 0, 0, 32'h1C0, 32'hA00, 1, 1);
      pred(32'h1C0, 1'b1);
      drive(1, 0, 1, 3'd0, 1, 0, 0, 32'h1C0, 32'hA00, 0, 1, 0);
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      chk("reset_mid_redirect", {31'd0, redirect}, 32'd0);
      chk("reset_mid_redirect_pc", redirect_pc, 32'd0);
      pred(32'h1C0, 1'b0);
      mem_valid = 1'b0; mem_branch = 1'b0;
      rst_n = 1'b1;
      exp_br = 0; exp_mis = 0; exp_jmp = 0;
      step();
      pred(32'h100, 1'b0);

`ifdef BRANCH_STATS_EN
      // 5 trained branches, 2 mispredicts
      br(0, 1, 3'd0, 1, 0, 0, 32'h100, 32'h200, 0, 1);
      br(0, 1, 3'd0, 1, 0, 0, 32'h100, 32'h200, 1, 1);
      br(0, 1, 3'd1, 1, 0, 0, 32'h100, 32'h200, 1, 0);
      br(0, 1, 3'd4, 0, 1, 0, 32'h100, 32'h200, 1, 1);
      br(0, 1, 3'd6, 0, 0, 0, 32'h100, 32'h200, 0, 0);
      step();
      chk("stat_branches_5", stat_branches, 32'd5);
      chk("stat_mispredicts_2", stat_mispredicts, 32'd2);
      chk("stat_jumps_0", stat_jumps, 32'd0);
`endif

      repeat (3) step();
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
